point_add_sub: RTL and testbench

- Sequential affine ECC point adder/subtractor over GF(p).
- Computes R = P + Q or R = P − Q, where P = (x1,y1) and Q = (x2,y2).
- Serves as the addition partner to the point-doubling unit inside the scalar-multiplication datapath.
- Uses a start/done handshake, an iterative modular inverse and a bit-serial modular multiplier; no wide combinational `%`.

---
 rtl/ecc_pkg.sv | 27 ++
 rtl/mod_inv_binary.sv | 79 +++++++
 rtl/point_add_sub.sv | 162 ++++++++++++++++
 tb/tb_point_add_sub.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared definitions for the affine ECC datapath: controller states and modular helpers.
// Helpers run on a fixed wide word; callers zero-extend n-bit operands and truncate results.
package ecc_pkg;

    localparam int ECC_MAXW = 256;
    typedef logic [ECC_MAXW-1:0] ecc_word_t;

    typedef enum logic [3:0] {
        IDLE, CHECK, DIFF, INV, MUL1, MUL2, XSUB, DIFF2, MUL3, YSUB, FINISH
    } ecc_state_e;

    // Operands are reduced (< m), so one conditional correction suffices.
    function automatic ecc_word_t mod_add(input ecc_word_t a, input ecc_word_t b, input ecc_word_t m);
        ecc_word_t s;
        s = a + b;
        return (s >= m) ? s - m : s;
    endfunction

    function automatic ecc_word_t mod_sub(input ecc_word_t a, input ecc_word_t b, input ecc_word_t m);
        return (a >= b) ? a - b : a + m - b;
    endfunction

    function automatic ecc_word_t mod_half(input ecc_word_t a, input ecc_word_t m);
        return a[0] ? (a + m) >> 1 : a >> 1;
    endfunction

endpackage

// File: rtl/mod_inv_binary.sv
// Iterative modular inverse x = a^-1 mod p (p odd prime, a != 0) by binary extended Euclid.
// Each step strips at least one bit from u or v, so a run takes at most 2n-2 steps.
module mod_inv_binary
    import ecc_pkg::*;
#(
    parameter int n = 231
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] a,
    input  logic [n-1:0] p,
    output logic [n-1:0] x,
    output logic         done
);

    localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};

    logic [n-1:0] u_q, v_q, x1_q, x2_q, p_q, x_q;
    logic         run_q, done_q;

    function automatic logic [n-1:0] fsub(input logic [n-1:0] l, input logic [n-1:0] r, input logic [n-1:0] m);
        return n'(mod_sub(ecc_word_t'(l), ecc_word_t'(r), ecc_word_t'(m)));
    endfunction

    function automatic logic [n-1:0] fhalf(input logic [n-1:0] l, input logic [n-1:0] m);
        return n'(mod_half(ecc_word_t'(l), ecc_word_t'(m)));
    endfunction

    // Invariants: x1*a == u and x2*a == v (mod p).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_q    <= '0;
            v_q    <= '0;
            x1_q   <= '0;
            x2_q   <= '0;
            p_q    <= '0;
            x_q    <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start && !run_q) begin
                u_q   <= a;
                v_q   <= p;
                x1_q  <= ONE;
                x2_q  <= '0;
                p_q   <= p;
                run_q <= 1'b1;
            end else if (run_q) begin
                if (u_q == ONE) begin
                    x_q    <= x1_q;
                    done_q <= 1'b1;
                    run_q  <= 1'b0;
                end else if (v_q == ONE) begin
                    x_q    <= x2_q;
                    done_q <= 1'b1;
                    run_q  <= 1'b0;
                end else if (!u_q[0]) begin
                    u_q  <= u_q >> 1;
                    x1_q <= fhalf(x1_q, p_q);
                end else if (!v_q[0]) begin
                    v_q  <= v_q >> 1;
                    x2_q <= fhalf(x2_q, p_q);
                end else if (u_q >= v_q) begin
                    u_q  <= (u_q - v_q) >> 1;
                    x1_q <= fhalf(fsub(x1_q, x2_q, p_q), p_q);
                end else begin
                    v_q  <= (v_q - u_q) >> 1;
                    x2_q <= fhalf(fsub(x2_q, x1_q, p_q), p_q);
                end
            end
        end
    end

    assign x    = x_q;
    assign done = done_q;

endmodule

// File: rtl/point_add_sub.sv
// Sequential affine point adder/subtractor R = P +/- Q over GF(p), sharing one bit-serial
// multiplier across the three products and an iterative inverse for the slope denominator.
module point_add_sub
    import ecc_pkg::*;
#(
    parameter int n = 231
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         sub,
    input  logic [n-1:0] p,
    input  logic [n-1:0] x1,
    input  logic [n-1:0] y1,
    input  logic [n-1:0] x2,
    input  logic [n-1:0] y2,
    input  logic         inf1,
    input  logic         inf2,
    output logic [n-1:0] x3,
    output logic [n-1:0] y3,
    output logic         infinity,
    output logic         need_double,
    output logic         busy,
    output logic         done,
    output logic [3:0]   dbg_state
);

    localparam int            CW       = $clog2(n + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

    // Handshake: start is taken only in IDLE; done pulses one cycle when x3/y3/flags are valid.
    ecc_state_e    state_q;
    logic [n-1:0]  p_q, x1_q, y1_q, x2_q, y2e_q, dx_q, dy_q, lam_q, tmp_q, x3r_q, y3r_q;
    logic [n-1:0]  mul_a_q, mul_b_q, acc_q, x3_q, y3_q;
    logic [CW-1:0] cnt_q;
    logic          inf1_q, inf2_q, rinf_q, rnd_q, inv_start_q;
    logic          infinity_q, need_double_q, busy_q, done_q;
    logic [n-1:0]  y2e_d, dbl, acc_d, x3r_d, t_d, inv_x;
    logic          inv_done;

    function automatic logic [n-1:0] fsub(input logic [n-1:0] l, input logic [n-1:0] r, input logic [n-1:0] m);
        return n'(mod_sub(ecc_word_t'(l), ecc_word_t'(r), ecc_word_t'(m)));
    endfunction

    function automatic logic [n-1:0] fadd(input logic [n-1:0] l, input logic [n-1:0] r, input logic [n-1:0] m);
        return n'(mod_add(ecc_word_t'(l), ecc_word_t'(r), ecc_word_t'(m)));
    endfunction

    mod_inv_binary #(.n(n)) u_inv (
        .clk   (clk),
        .reset (reset),
        .start (inv_start_q),
        .a     (dx_q),
        .p     (p_q),
        .x     (inv_x),
        .done  (inv_done)
    );

    // One MSB-first multiplier step: acc = 2*acc (+ b when the current bit is set), mod p.
    always_comb begin
        y2e_d = sub ? fsub('0, y2, p) : y2;
        dbl   = fadd(acc_q, acc_q, p_q);
        acc_d = mul_a_q[n-1] ? fadd(dbl, mul_b_q, p_q) : dbl;
        x3r_d = fsub(fsub(tmp_q, x1_q, p_q), x2_q, p_q);
        t_d   = fsub(x1_q, x3r_q, p_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            {p_q, x1_q, y1_q, x2_q, y2e_q, dx_q, dy_q, lam_q, tmp_q, x3r_q, y3r_q} <= '0;
            {mul_a_q, mul_b_q, acc_q, x3_q, y3_q} <= '0;
            cnt_q <= '0;
            {inf1_q, inf2_q, rinf_q, rnd_q, inv_start_q} <= '0;
            {infinity_q, need_double_q, busy_q, done_q} <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    {p_q, x1_q, y1_q, x2_q, y2e_q} <= {p, x1, y1, x2, y2e_d};
                    {inf1_q, inf2_q} <= {inf1, inf2};
                    infinity_q    <= 1'b0;
                    need_double_q <= 1'b0;
                    busy_q        <= 1'b1;
                    state_q       <= CHECK;
                end
                CHECK: begin
                    {rinf_q, rnd_q, x3r_q, y3r_q} <= '0;
                    state_q <= FINISH;
                    if (inf1_q && inf2_q) rinf_q <= 1'b1;
                    else if (inf1_q) {x3r_q, y3r_q} <= {x2_q, y2e_q};
                    else if (inf2_q) {x3r_q, y3r_q} <= {x1_q, y1_q};
                    else if (x1_q == x2_q && y1_q == y2e_q) rnd_q <= 1'b1;
                    else if (x1_q == x2_q) rinf_q <= 1'b1;
                    else state_q <= DIFF;
                end
                DIFF: begin
                    dx_q        <= fsub(x2_q, x1_q, p_q);
                    dy_q        <= fsub(y2e_q, y1_q, p_q);
                    inv_start_q <= 1'b1;
                    state_q     <= INV;
                end
                INV: begin
                    inv_start_q <= 1'b0;
                    if (inv_done) begin
                        {mul_a_q, mul_b_q, acc_q} <= {dy_q, inv_x, {n{1'b0}}};
                        cnt_q   <= CNT_LAST;
                        state_q <= MUL1;
                    end
                end
                MUL1, MUL2, MUL3: begin
                    acc_q   <= acc_d;
                    mul_a_q <= mul_a_q << 1;
                    cnt_q   <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        if (state_q == MUL1) begin
                            lam_q <= acc_d;
                            {mul_a_q, mul_b_q, acc_q} <= {acc_d, acc_d, {n{1'b0}}};
                            cnt_q   <= CNT_LAST;
                            state_q <= MUL2;
                        end else begin
                            tmp_q   <= acc_d;
                            state_q <= (state_q == MUL2) ? XSUB : YSUB;
                        end
                    end
                end
                XSUB: begin
                    x3r_q   <= x3r_d;
                    state_q <= DIFF2;
                end
                DIFF2: begin
                    {mul_a_q, mul_b_q, acc_q} <= {lam_q, t_d, {n{1'b0}}};
                    cnt_q   <= CNT_LAST;
                    state_q <= MUL3;
                end
                YSUB: begin
                    y3r_q   <= fsub(tmp_q, y1_q, p_q);
                    state_q <= FINISH;
                end
                FINISH: begin
                    x3_q          <= x3r_q;
                    y3_q          <= y3r_q;
                    infinity_q    <= rinf_q;
                    need_double_q <= rnd_q;
                    done_q        <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x3          = x3_q;
    assign y3          = y3_q;
    assign infinity    = infinity_q;
    assign need_double = need_double_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_point_add_sub.sv
// Directed bench for point_add_sub on p = 23, curve y^2 = x^3 + x + 1, with scoreboard monitor.
module tb_point_add_sub;
  import ecc_pkg::*;

  localparam int N = 8;
  localparam logic [N-1:0] P23 = 8'd23;

  logic         clk = 1'b0;
  logic         reset, start, sub, inf1, inf2;
  logic [N-1:0] p, x1, y1, x2, y2;
  logic [N-1:0] x3, y3;
  logic         infinity, need_double, busy, done;
  logic [3:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [2*N+1:0] exp_q[$];
  logic [2*N+1:0] mon_e;
  logic [N-1:0]   prev_x = '0;
  logic [N-1:0]   prev_y = '0;

  point_add_sub #(.n(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .sub         (sub),
    .p           (p),
    .x1          (x1),
    .y1          (y1),
    .x2          (x2),
    .y2          (y2),
    .inf1        (inf1),
    .inf2        (inf2),
    .x3          (x3),
    .y3          (y3),
    .infinity    (infinity),
    .need_double (need_double),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending request");
      end else begin
        mon_e = exp_q.pop_front();
        chk("x3", 32'(x3), 32'(mon_e[2*N+1:N+2]));
        chk("y3", 32'(y3), 32'(mon_e[N+1:2]));
        chk("infinity", 32'(infinity), 32'(mon_e[1]));
        chk("need_double", 32'(need_double), 32'(mon_e[0]));
      end
    end
  end

  task automatic scramble();
    x1   = 8'($urandom_range(0, 255));
    y1   = 8'($urandom_range(0, 255));
    x2   = 8'($urandom_range(0, 255));
    y2   = 8'($urandom_range(0, 255));
    sub  = 1'($urandom_range(0, 1));
    inf1 = 1'($urandom_range(0, 1));
    inf2 = 1'($urandom_range(0, 1));
  endtask

  // driver: issue one request, push its expectation, time it and check the protocol around it
  task automatic do_req(input logic s, input logic [N-1:0] ax1, ay1, ax2, ay2, input logic i1, i2,
                        input logic [N-1:0] ex, ey, input logic einf, end_,
                        input int max_lat, input int exact_lat, input int ghost);
    int lat;
    @(negedge clk);
    sub = s; x1 = ax1; y1 = ay1; x2 = ax2; y2 = ay2; inf1 = i1; inf2 = i2;
    start = 1'b1;
    exp_q.push_back({ex, ey, einf, end_});
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble();
    lat = 1;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("infinity_cleared", 32'(infinity), 32'd0);
    chk("need_double_cleared", 32'(need_double), 32'd0);
    chk("x3_hold_while_busy", 32'(x3), 32'(prev_x));
    chk("y3_hold_while_busy", 32'(y3), 32'(prev_y));
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      start = (ghost != 0 && lat == ghost) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
    end else begin
      chk("latency_bound", 32'(lat <= max_lat), 32'd1);
      if (exact_lat != 0) chk("latency_exact", 32'(lat), 32'(exact_lat));
      chk("busy_at_done", 32'(busy), 32'd0);
      prev_x = ex;
      prev_y = ey;
      @(posedge clk);
      #1;
      chk("done_single_cycle", 32'(done), 32'd0);
      @(posedge clk);
      #1;
      chk("x3_hold_idle", 32'(x3), 32'(ex));
      chk("y3_hold_idle", 32'(y3), 32'(ey));
    end
  endtask

  initial begin
    int w;
    reset = 1'b0; start = 1'b0; sub = 1'b0; inf1 = 1'b0; inf2 = 1'b0;
    p = P23; x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x3", 32'(x3), 32'd0);
    chk("rst_y3", 32'(y3), 32'd0);
    chk("rst_infinity", 32'(infinity), 32'd0);
    chk("rst_need_double", 32'(need_double), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1;

    // general add, with a stray start pulse while busy
    do_req(1'b0, 8'd3, 8'd10, 8'd9, 8'd7, 1'b0, 1'b0, 8'd17, 8'd20, 1'b0, 1'b0, 49, 0, 5);
    // general subtract
    do_req(1'b1, 8'd3, 8'd10, 8'd9, 8'd7, 1'b0, 1'b0, 8'd12, 8'd4, 1'b0, 1'b0, 49, 0, 0);
    // inverse pairs
    do_req(1'b0, 8'd3, 8'd10, 8'd3, 8'd13, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 3, 3, 0);
    do_req(1'b1, 8'd3, 8'd10, 8'd3, 8'd10, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 3, 3, 0);
    // equal points
    do_req(1'b0, 8'd3, 8'd10, 8'd3, 8'd10, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 3, 3, 0);
    // identities
    do_req(1'b1, 8'd0, 8'd0, 8'd9, 8'd7, 1'b1, 1'b0, 8'd9, 8'd16, 1'b0, 1'b0, 3, 3, 0);
    do_req(1'b0, 8'd5, 8'd5, 8'd9, 8'd7, 1'b1, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0, 3, 3, 0);
    do_req(1'b0, 8'd3, 8'd10, 8'd9, 8'd7, 1'b0, 1'b1, 8'd3, 8'd10, 1'b0, 1'b0, 3, 3, 0);
    do_req(1'b1, 8'd0, 8'd0, 8'd4, 8'd0, 1'b1, 1'b0, 8'd4, 8'd0, 1'b0, 1'b0, 3, 3, 0);
    // second general add: (0,1) + (1,7) = (12,19)
    do_req(1'b0, 8'd0, 8'd1, 8'd1, 8'd7, 1'b0, 1'b0, 8'd12, 8'd19, 1'b0, 1'b0, 49, 0, 0);

    // abort during MUL2
    @(negedge clk);
    sub = 1'b0; x1 = 8'd3; y1 = 8'd10; x2 = 8'd9; y2 = 8'd7; inf1 = 1'b0; inf2 = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    w = 0;
    while (dbg_state != MUL2 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("reached_mul2", 32'(dbg_state == MUL2), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_x3", 32'(x3), 32'd0);
    chk("abort_y3", 32'(y3), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'(IDLE));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    prev_x = '0;
    prev_y = '0;
    do_req(1'b0, 8'd3, 8'd10, 8'd9, 8'd7, 1'b0, 1'b0, 8'd17, 8'd20, 1'b0, 1'b0, 49, 0, 0);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
